shift_sequencer: RTL and testbench

Multi-cycle shift-by-N unit for the datapath. It takes an 8-bit operand and a 3-bit shift amount, then applies one single-position shift per clock. Supported modes are logical left, logical right and arithmetic right. It sits between the ALU operand latch and the writeback/flag logic, and produces the shifted result plus the last bit shifted out as a carry flag.

---
 rtl/shift_sequencer_pkg.sv | 31 +++
 rtl/shift_sequencer_if.sv | 33 +++
 rtl/shift_sequencer_step.sv | 49 ++++
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the multi-cycle shift sequencer: default operand and
// shift-amount widths, FSM state encoding and shift mode encoding.
// The mode is {arithmetic, direction}. Arithmetic left behaves the same as
// logical left.
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;   // clog2(WIDTH_DEF)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ZERO  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASL = 2'b10,
    ASR = 2'b11
  } mode_t;

  // Build the mode code from the two captured control bits.
  function automatic mode_t make_mode(input logic arithmetic, input logic direction);
    return mode_t'({arithmetic, direction});
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
// Request/response bundle of the shift sequencer.
//   master : drives start, operand, amount, direction, arithmetic;
//            observes busy, done, result, carry
//   slave  : the sequencer itself (the mirror image of master)
// -----------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) ();

  logic             start;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] amount;
  logic             direction;
  logic             arithmetic;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;

  modport master (
    output start, operand, amount, direction, arithmetic,
    input  busy, done, result, carry
  );

  modport slave (
    input  start, operand, amount, direction, arithmetic,
    output busy, done, result, carry
  );

endinterface

// File: rtl/shift_sequencer_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-position shifter.
//   w          : current working value
//   direction  : 1 = right, 0 = left
//   arithmetic : 1 = sign-fill on a right shift (no effect on a left shift)
//   w_next     : value after one shift position
//   out_bit    : the bit that falls off the end
// -----------------------------------------------------------------------------
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] w,
  input  logic             direction,
  input  logic             arithmetic,
  output logic [WIDTH-1:0] w_next,
  output logic             out_bit
);

  mode_t mode;
  assign mode = make_mode(arithmetic, direction);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    w_next  = w;
    out_bit = 1'b0;
    case (mode)
      LSL, ASL: begin
        w_next  = {w[WIDTH-2:0], 1'b0};
        out_bit = w[WIDTH-1];
      end
      LSR: begin
        w_next  = {1'b0, w[WIDTH-1:1]};
        out_bit = w[0];
      end
      ASR: begin
        w_next  = {w[WIDTH-1], w[WIDTH-1:1]};
        out_bit = w[0];
      end
      default: begin
        w_next  = w;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle shift-by-N unit. A request accepted in IDLE captures the operand
// and the shift controls, then one single-position shift is applied per clock
// until the requested amount is used up. The last bit shifted out is reported
// as carry. A zero amount takes one cycle and returns the operand unchanged.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : shift_sequencer_if.slave
//           (start/operand/amount/direction/arithmetic in,
//            busy/done/result/carry out)
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q;
  logic [CNT_W-1:0] count_q;
  logic             dir_q;
  logic             arith_q;
  logic             carry_q;
  logic             done_q;

  logic [WIDTH-1:0] step_w;
  logic             step_bit;

  // A request is taken only while idle. A start that arrives while busy is dropped.
  logic accept;
  logic last_step;
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (state_q == SHIFT) && (count_q == CNT_W'(1));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w          (w_q),
    .direction  (dir_q),
    .arithmetic (arith_q),
    .w_next     (step_w),
    .out_bit    (step_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.amount == '0) ? ZERO : SHIFT;
      end
      SHIFT: begin
        if (count_q == CNT_W'(1)) state_d = IDLE;
      end
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. busy covers every non-IDLE cycle. The done cycle is already
  // IDLE, so a new start can be accepted in that cycle.
  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = done_q;
    bus.result = w_q;
    bus.carry  = carry_q;
  end

  // Datapath. The working register is the visible result. It only changes on
  // accept or during SHIFT, so it holds while idle. A ZERO request needs no
  // update: the operand and the cleared carry were loaded on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q     <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_step || (state_q == ZERO);
      if (accept) begin
        w_q     <= bus.operand;
        count_q <= bus.amount;
        dir_q   <= bus.direction;
        arith_q <= bus.arithmetic;
        carry_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        w_q     <= step_w;
        carry_q <= step_bit;
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed test of shift_sequencer. Each case has hand-computed expected
// result, carry and latency.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic clk;
  logic reset;

  int n_checked = 0;
  int n_failed  = 0;

  shift_sequencer_if #(.WIDTH(8), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done.
  // Checks: busy during the shift, latency, result, carry, the one-cycle
  // done pulse and that result stays put afterwards.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] amt,
                        input logic dir, input logic arith,
                        input logic [7:0] exp_res, input logic exp_c, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.operand    = op;
    bus.amount     = amt;
    bus.direction  = dir;
    bus.arithmetic = arith;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    // These inputs are don't-care after the accepting edge.
    bus.operand    = ~op;
    bus.amount     = ~amt;
    bus.direction  = ~dir;
    bus.arithmetic = ~arith;
    check({tag, "/busy_e0"}, 32'(bus.busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && lat < 16) check({tag, "/busy_mid"}, 32'(bus.busy), 32'd1);
    end while (!bus.done && lat < 16);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "/result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "/carry"}, 32'(bus.carry), 32'(exp_c));
    @(posedge clk);
    #1;
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/result_hold"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    int done_seen;

    bus.start      = 1'b0;
    bus.operand    = '0;
    bus.amount     = '0;
    bus.direction  = 1'b0;
    bus.arithmetic = 1'b0;
    reset          = 1'b1;

    // Reset state.
    #12;
    check("rst/busy",   32'(bus.busy),   32'd0);
    check("rst/done",   32'(bus.done),   32'd0);
    check("rst/result", 32'(bus.result), 32'd0);
    check("rst/carry",  32'(bus.carry),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-shift: 0xFF LSL 6. The shift is aborted after two steps.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operand   = 8'hFF;
    bus.amount    = 3'd6;
    bus.direction = 1'b0;
    bus.arithmetic = 1'b0;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort/busy_pre", 32'(bus.busy), 32'd1);
    check("abort/w_pre", 32'(bus.result), 32'hFC);
    #2;
    reset = 1'b1;
    #1;
    check("abort/busy",   32'(bus.busy),   32'd0);
    check("abort/result", 32'(bus.result), 32'd0);
    check("abort/carry",  32'(bus.carry),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort/no_done", 32'(done_seen), 32'd0);

    // Main function.
    run_op("lsl1",  8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1);
    run_op("asr3",  8'h94, 3'd3, 1'b1, 1'b1, 8'hF2, 1'b1, 3);
    run_op("lsr7",  8'hB5, 3'd7, 1'b1, 1'b0, 8'h01, 1'b0, 7);
    run_op("asl2",  8'h40, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 2);
    run_op("zero",  8'h5A, 3'd0, 1'b1, 1'b1, 8'h5A, 1'b0, 1);
    run_op("asr_pos", 8'h52, 3'd2, 1'b1, 1'b1, 8'h14, 1'b1, 2);

    // start held high while busy, then a back-to-back request in the done cycle.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.operand    = 8'h0F;
    bus.amount     = 3'd4;
    bus.direction  = 1'b0;
    bus.arithmetic = 1'b0;
    @(posedge clk); #1;
    // The starts seen while busy carry different operands. They must be ignored.
    bus.operand    = 8'hAA;
    bus.amount     = 3'd7;
    bus.direction  = 1'b1;
    bus.arithmetic = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("b2b/first_busy", 32'(bus.busy), 32'd1);
      check("b2b/first_nodone", 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1;
    check("b2b/first_done",   32'(bus.done),   32'd1);
    check("b2b/first_result", 32'(bus.result), 32'hF0);
    check("b2b/first_carry",  32'(bus.carry),  32'd0);
    bus.operand    = 8'h80;
    bus.amount     = 3'd1;
    bus.direction  = 1'b1;
    bus.arithmetic = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b/second_busy", 32'(bus.busy), 32'd1);
    check("b2b/second_nodone", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("b2b/second_done",   32'(bus.done),   32'd1);
    check("b2b/second_result", 32'(bus.result), 32'hC0);
    check("b2b/second_carry",  32'(bus.carry),  32'd0);
    @(posedge clk); #1;
    check("b2b/idle_nodone", 32'(bus.done), 32'd0);
    check("b2b/idle_busy",   32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
